mult_accum_buffer: RTL and testbench

//  Downstream consumer of the pipelined signed multiplier's result stream.
//  - Sums every ACC_LEN consecutive valid products into one signed accumulator value.
//  - Queues each completed sum in a DEPTH-entry FIFO and drains it over a ready/valid port.
//  - The multiplier cannot stall, so this block never backpressures upstream.
//  - Overrun is flagged, never stalled.

---
 rtl/mult_accum_buffer_if.sv | 30 +++
 rtl/mult_accum_buffer.sv | 163 ++++++++++++++++
 tb/tb_mult_accum_buffer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_accum_buffer_if.sv
// Stream bundle for mult_accum_buffer: the product input beats and the
// ready/valid drain port for completed sums.
// master = producer/consumer side (testbench or surrounding logic),
// slave  = the accumulator buffer itself.
interface mult_accum_buffer_if #(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 72
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mult_accum_buffer.sv
// mult_accum_buffer: sums every ACC_LEN valid signed products into one
// ACC_W-bit value and queues the sums in a DEPTH-entry show-ahead FIFO.
// Upstream is never stalled; a sum that finds the FIFO full (with no pop
// on the same edge) is dropped and ovf_drop is raised.
// Optional feature macro: MAC_SAT_EN -- saturating accumulation with a
// sticky sat_flag. When undefined, adds wrap and sat_flag is tied 0.
module mult_accum_buffer #(
    parameter int DATA_W  = 64,
    parameter int ACC_W   = 72,
    parameter int ACC_LEN = 4,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    mult_accum_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf_drop,
    output logic                     sat_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] mem_q [DEPTH];

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic                    beat, last_beat, pop, push_ok, drop;

    assign in_ext   = ACC_W'(bus.in_data);
    // Starting a group means the old accumulator value is irrelevant.
    assign acc_base = (cnt_q == '0) ? '0 : acc_q;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_wide;
    logic           sat_hit;
    logic           sat_q, sat_d;

    // Add one bit wider; the top two bits disagree exactly on overflow.
    always_comb begin
        sum_wide = {acc_base[ACC_W-1], acc_base} + {in_ext[ACC_W-1], in_ext};
        sat_hit  = 1'b0;
        acc_next = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sat_hit  = 1'b1;
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Sticky saturation indicator, cleared only by clr or reset.
    always_comb begin
        sat_d = sat_q;
        if (clr) begin
            sat_d = 1'b0;
        end else if (beat && sat_hit) begin
            sat_d = 1'b1;
        end
    end

    // Saturation flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign acc_next = acc_base + in_ext;
    assign sat_flag = 1'b0;
`endif

    // clr wins over any input beat or pop in the same cycle.
    assign beat      = bus.in_valid && !clr;
    assign last_beat = beat && (cnt_q == CW'(ACC_LEN - 1));
    assign pop       = (level_q != '0) && bus.out_ready && !clr;
    // A full FIFO still accepts the push when the head leaves on this edge.
    assign push_ok   = last_beat && ((level_q != LW'(DEPTH)) || pop);
    assign drop      = last_beat && (level_q == LW'(DEPTH)) && !pop;

    // Next-state for accumulator, beat count, pointers, level and overrun flag.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (clr) begin
            acc_d    = '0;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (beat) begin
                if (last_beat) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + LW'(push_ok) - LW'(pop);
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control and accumulator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= acc_next;
        end
    end

    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fifo_level    = level_q;
    assign ovf_drop      = ovf_q;
endmodule

// File: tb/tb_mult_accum_buffer.sv
// Self-checking bench for mult_accum_buffer. A scoreboard queue holds the
// sums the FIFO should contain; every pop is compared against its head.
// A second instance with ACC_W=64 exercises the overflow behaviour.
module tb_mult_accum_buffer;
    localparam int DEPTH = 8;
    localparam int ACC_LEN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic clr2 = 1'b0;
    logic [3:0] fifo_level, fifo_level2;
    logic ovf_drop, ovf_drop2, sat_flag, sat_flag2;

    mult_accum_buffer_if #(.DATA_W(64), .ACC_W(72)) bus ();
    mult_accum_buffer_if #(.DATA_W(64), .ACC_W(64)) bus2 ();

    mult_accum_buffer #(.DATA_W(64), .ACC_W(72), .ACC_LEN(ACC_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus),
        .fifo_level(fifo_level), .ovf_drop(ovf_drop), .sat_flag(sat_flag)
    );

    mult_accum_buffer #(.DATA_W(64), .ACC_W(64), .ACC_LEN(ACC_LEN), .DEPTH(DEPTH)) dut_w64 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .bus(bus2),
        .fifo_level(fifo_level2), .ovf_drop(ovf_drop2), .sat_flag(sat_flag2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    longint sb[$];
    int     m_cnt = 0;
    longint m_acc = 0;
    logic   m_ovf = 1'b0;
    logic   push_pending = 1'b0;
    longint push_val = 0;

    task automatic chk(input string tag, input logic signed [127:0] got,
                       input logic signed [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s: %0d ok", tag, got);
        end
    endtask

    // One clock edge; updates the scoreboard for the pop and push of this edge.
    task automatic tick();
        if (clr) begin
            sb.delete();
            m_cnt = 0;
            m_acc = 0;
            m_ovf = 1'b0;
            push_pending = 1'b0;
        end else begin
            if (bus.out_ready && sb.size() > 0) begin
                chk("pop_valid", bus.out_valid, 1);
                chk("pop_data", bus.out_data, sb.pop_front());
            end
            if (push_pending) begin
                if (sb.size() < DEPTH) sb.push_back(push_val);
                else m_ovf = 1'b1;
                push_pending = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input longint v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        m_acc = (m_cnt == 0) ? v : m_acc + v;
        if (m_cnt == ACC_LEN - 1) begin
            push_pending = 1'b1;
            push_val = m_acc;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic group(input longint a, input longint b, input longint c, input longint d);
        beat(a); beat(b); beat(c); beat(d);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
        chk("drained_valid", bus.out_valid, 0);
        chk("drained_level", fifo_level, 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", ovf_drop, 0);
        chk("rst_sat", sat_flag, 0);
        rst_n = 1'b1;
        tick();

        // 1. Reset mid-sum with a sum already queued.
        group(25, 25, 25, 25);
        chk("pre_rst_valid", bus.out_valid, 1);
        beat(7); beat(7);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_data", bus.out_data, 0);
        chk("async_rst_level", fifo_level, 0);
        sb.delete(); m_cnt = 0; m_acc = 0; m_ovf = 1'b0; push_pending = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        group(5, 5, 5, 5);
        chk("post_rst_sum", bus.out_data, 20);
        drain();

        // 2. Basic sum with the consumer always ready.
        bus.out_ready = 1'b1;
        beat(1); beat(2); beat(3);
        chk("basic_early_valid", bus.out_valid, 0);
        beat(-10);
        chk("basic_valid", bus.out_valid, 1);
        chk("basic_sum", bus.out_data, -4);
        tick();
        chk("basic_one_cycle", bus.out_valid, 0);
        chk("basic_empty_data", bus.out_data, 0);
        bus.out_ready = 1'b0;

        // 3. Overrun: nine sums into an eight-deep FIFO.
        for (int k = 1; k <= 9; k++) group(k, 0, 0, 0);
        chk("ovr_level", fifo_level, DEPTH);
        chk("ovr_flag", ovf_drop, m_ovf);
        drain();
        chk("ovr_sticky", ovf_drop, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", ovf_drop, 0);

        // 4. Full boundary: push and pop on the same edge.
        for (int k = 11; k <= 18; k++) group(k, 0, 0, 0);
        chk("full_level", fifo_level, DEPTH);
        beat(19); beat(0); beat(0);
        bus.out_ready = 1'b1;
        beat(0);
        bus.out_ready = 1'b0;
        chk("full_pp_level", fifo_level, DEPTH);
        chk("full_pp_ovf", ovf_drop, 0);
        drain();

        // 6. Clear colliding with a beat and a pop.
        for (int k = 1; k <= 9; k++) group(k * 3, 1, 0, 0);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        bus.out_ready = 1'b0;
        chk("col_level", fifo_level, 3);
        chk("col_ovf", ovf_drop, 1);
        beat(50);
        clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 1000; bus.out_ready = 1'b1;
        tick();
        clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        chk("col_level0", fifo_level, 0);
        chk("col_ovf0", ovf_drop, 0);
        chk("col_valid0", bus.out_valid, 0);
        chk("col_data0", bus.out_data, 0);
        group(1, 1, 1, 1);
        chk("col_next_sum", bus.out_data, 4);
        chk("col_next_level", fifo_level, 1);
        drain();
        chk("sat_narrow", sat_flag, 0);

        // 5. Saturation / wrap on the 64-bit accumulator instance.
        for (int i = 0; i < 4; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data = 64'sh4000_0000_0000_0000;
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        chk("sat_valid", bus2.out_valid, 1);
`ifdef MAC_SAT_EN
        chk("sat_data", bus2.out_data, 64'sh7FFF_FFFF_FFFF_FFFF);
        chk("sat_flag", sat_flag2, 1);
`else
        chk("wrap_data", bus2.out_data, 0);
        chk("wrap_flag", sat_flag2, 0);
`endif
        @(posedge clk); #1;
        chk("sat_popped", bus2.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
